// File: rtl/encoder8to3_seq_if.sv
// encoder8to3_seq_if: request/code handshake bundle
// for the sequential 8-to-3 priority encoder.
interface encoder8to3_seq_if;
  logic       E;
  logic       load;
  logic [7:0] D;
  logic       ready;
  logic [2:0] Y;
  logic       V;
  logic       busy;
  logic [3:0] N;
  logic       done;
  logic       zero;

  modport master (
    output E,
    output load,
    output D,
    output ready,
    input  Y,
    input  V,
    input  busy,
    input  N,
    input  done,
    input  zero
  );

  modport slave (
    input  E,
    input  load,
    input  D,
    input  ready,
    output Y,
    output V,
    output busy,
    output N,
    output done,
    output zero
  );
endinterface

// File: rtl/encoder8to3_seq.sv
// encoder8to3_seq: captures an 8-bit request vector and
// delivers set-bit indices, highest first, one per handshake.
module encoder8to3_seq (
  input  logic               clk,
  input  logic               rst_n,
  encoder8to3_seq_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] p;
  logic [7:0] p_n;
  logic [3:0] n;
  logic [3:0] n_n;
  logic       done_q;
  logic       done_n;
  logic       zero_q;
  logic       zero_n;
  logic [2:0] y;
  logic       v;
  logic       hs;
  logic [7:0] p_clr;

  function automatic logic [3:0] popcnt(
    input logic [7:0] vec
  );
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++)
      c = c + {3'b000, vec[i]};
    return c;
  endfunction

  // highest pending line wins; later (higher) bits override
  always_comb begin
    y = 3'd0;
    for (int i = 0; i < 8; i++)
      if (p[i])
        y = 3'(i);
  end

  assign v     = (state == DRAIN) && bus.E;
  assign hs    = v && bus.ready;
  assign p_clr = p & ~(8'd1 << y);

  // next-state: capture in IDLE, retire one line per handshake
  always_comb begin
    state_n = state;
    p_n     = p;
    n_n     = n;
    done_n  = 1'b0;
    zero_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.load && bus.E) begin
          p_n = bus.D;
          n_n = popcnt(bus.D);
          if (bus.D == 8'h00)
            zero_n = 1'b1;
          else
            state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (hs) begin
          p_n = p_clr;
          if (p_clr == 8'h00) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // state, pending lines, count and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      p      <= 8'h00;
      n      <= 4'd0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state  <= state_n;
      p      <= p_n;
      n      <= n_n;
      done_q <= done_n;
      zero_q <= zero_n;
    end
  end

  assign bus.Y    = y;
  assign bus.V    = v;
  assign bus.busy = (state == DRAIN);
  assign bus.N    = n;
  assign bus.done = done_q;
  assign bus.zero = zero_q;

endmodule

// File: doc/encoder8to3_seq.md
ENCODER8TO3_SEQ -- requirements
Module: encoder8to3_seq

Interface
REQ-001 SHALL have no parameters; widths are fixed at 8 request lines and a 3-bit code.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 E  input  1  enable; 1 = capture and output permitted, 0 = block paused.
REQ-005 load  input  1  capture strobe for D; sampled at rising clk.
REQ-006 D  input  8  request vector; bit i set = line i active.
REQ-007 ready  input  1  downstream accepts current code when ready=1 and V=1.
REQ-008 Y  output  3  binary index of highest-numbered pending line.
REQ-009 V  output  1  Y is valid.
REQ-010 busy  output  1  1 while any captured line remains undelivered.
REQ-011 N  output  4  count of set bits in the last captured D, 0..8.
REQ-012 done  output  1  one-cycle pulse after the final code of a vector is accepted.
REQ-013 zero  output  1  one-cycle pulse when a capture sees D=8'h00.

Function
REQ-014 SHALL implement two states: IDLE and DRAIN; an internal 8-bit register P holds pending lines.
REQ-015 In IDLE, load=1 and E=1 at a rising edge SHALL set P<=D and N<=popcount(D).
REQ-016 If that captured D is nonzero, the state SHALL become DRAIN; if D=0, the state SHALL stay IDLE and zero SHALL be 1 for the next cycle only.
REQ-017 In IDLE, load with E=0 SHALL be ignored.
REQ-018 In DRAIN, load SHALL be ignored; P and N SHALL NOT change from D.
REQ-019 Y SHALL be combinational from P: index of the highest set bit (bit 7 highest priority); Y=3'b000 when P=0.
REQ-020 V SHALL equal (state==DRAIN) AND E; busy SHALL equal (state==DRAIN), independent of E.
REQ-021 Latency: V SHALL rise in the cycle immediately following the capturing edge (one clock).
REQ-022 Handshake: on a rising edge with V=1 and ready=1, the bit P[Y] SHALL be cleared; exactly one code is delivered per handshake.
REQ-023 V=1 with ready=0 SHALL hold Y, V and P stable.
REQ-024 E=0 in DRAIN SHALL force V=0 and freeze P; draining resumes with the same Y when E returns to 1.
REQ-025 When the handshake clears the last set bit of P, the state SHALL return to IDLE at that edge and done SHALL be 1 for exactly the next cycle.
REQ-026 A load asserted in the same cycle as the final handshake SHALL be ignored (state is DRAIN at that edge); capture is possible from the following cycle.
REQ-027 done and zero SHALL be registered and never both 1 in the same cycle.
REQ-028 A vector with k set bits SHALL produce exactly k handshakes, in strictly descending index order.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force state=IDLE, P=8'h00, N=4'd0, done=0, zero=0; hence Y=3'b000, V=0, busy=0.
REQ-030 Reset asserted mid-DRAIN SHALL discard all pending lines with no done pulse; operation restarts from IDLE after rst_n=1.

Verification
REQ-031 Reset, E=1, load D=8'b1010_0101, ready=1 -> N=4, V=1 next cycle; Y sequence 7,5,2,0 on consecutive cycles; busy falls with the last handshake; done pulses once.
REQ-032 Load D=8'h80, ready=0 for 5 cycles then 1 -> Y=7, V=1 held for 5 cycles; one handshake; done one cycle later.
REQ-033 Load D=8'h00 -> zero=1 for one cycle, N=0, V=0, busy=0, no done.
REQ-034 Load D=8'hFF, ready=1, drop E for 3 cycles after Y=4 appears -> V=0 and Y=4 held while E=0; resume 4,3,2,1,0; 8 handshakes total.
REQ-035 Load D=8'h0C, assert load with D=8'hFF during DRAIN -> ignored; codes 3,2 only; N stays 2.
REQ-036 Load D=8'h66, pulse rst_n low between clk edges after first handshake -> V, busy, N, Y go 0 immediately; no done; later load D=8'h01 gives Y=0 then done.
